mux_a_not_a: RTL and testbench



---
 rtl/mux_a_not_a.sv | 83 ++++++++
 tb/tb_mux_a_not_a.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mux_a_not_a.sv
// mux_a_not_a: selectable inverter with registered copy and invert-cycle counter.
//   y       = a ^ {WIDTH{c}} (combinational, valid during reset)
//   y_q     = registered y, loaded on enabled cycles
//   inv_cnt = saturating count of enabled cycles with c=1, clr has priority
//   inv_sat = inv_cnt at its maximum value
// Optional feature macro: MUX_A_NOT_A_PARITY_EN adds par_q, the registered
// XOR-reduction of y, loaded on enabled cycles.
module mux_a_not_a #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             c,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [CNT_W-1:0] inv_cnt,
`ifdef MUX_A_NOT_A_PARITY_EN
  output logic             inv_sat,
  output logic             par_q
`else
  output logic             inv_sat
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_next;

  // Per-bit polarity select; plain XOR keeps an X on c visible on y.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
      assign y[gi] = a[gi] ^ c;
    end
  endgenerate

  // Counter is zero in reset, so the saturation flag is zero there too.
  assign inv_sat = (inv_cnt == CNT_MAX);

  // Registered copy of the result, updated only on enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else if (en) begin
      y_q <= y;
    end
  end

  // Next count: clear wins, then saturating increment on enabled invert cycles.
  always_comb begin
    cnt_next = inv_cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (en && c && !inv_sat) begin
      cnt_next = inv_cnt + 1'b1;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_cnt <= '0;
    end else begin
      inv_cnt <= cnt_next;
    end
  end

`ifdef MUX_A_NOT_A_PARITY_EN
  // Registered parity of the selected result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (en) begin
      par_q <= ^y;
    end
  end
`endif

endmodule

// File: tb/tb_mux_a_not_a.sv
// Scoreboard bench for mux_a_not_a: the driver issues one stimulus per cycle
// and queues the expected outputs from a behavioural model; the monitor pops
// and compares on every falling edge.
module tb_mux_a_not_a;

  localparam int W     = 8;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  a = '0;
  logic          c = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  y, y_q;
  logic [CW-1:0] inv_cnt;
  logic          inv_sat;
  logic          par_q;

  logic          a1, y1, y1_q, inv1_sat;
  logic [7:0]    inv1_cnt;
  logic          par1_q;

  always #5 clk = ~clk;

  mux_a_not_a #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .c(c), .en(en), .clr(clr),
    .y(y), .y_q(y_q), .inv_cnt(inv_cnt),
`ifdef MUX_A_NOT_A_PARITY_EN
    .inv_sat(inv_sat), .par_q(par_q)
`else
    .inv_sat(inv_sat)
`endif
  );

  // Single-bit instance used for the exhaustive 1-bit truth table.
  assign a1 = a[0];
  mux_a_not_a #(.WIDTH(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .c(c), .en(en), .clr(clr),
    .y(y1), .y_q(y1_q), .inv_cnt(inv1_cnt),
`ifdef MUX_A_NOT_A_PARITY_EN
    .inv_sat(inv1_sat), .par_q(par1_q)
`else
    .inv_sat(inv1_sat)
`endif
  );

  typedef struct {
    logic [W-1:0] y;
    logic [W-1:0] y_q;
    int           cnt;
    logic         sat;
    logic         y1;
    logic         par;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model state.
  logic [W-1:0] m_yq;
  int           m_cnt;
  logic         m_par;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] sel(input logic [W-1:0] v, input logic inv);
    return inv ? ~v : v;
  endfunction

  // One cycle: apply the edge to the model, then drive new inputs and queue
  // the outputs expected before the next edge.
  task automatic step(input logic [W-1:0] na, input logic nc, input logic ne,
                      input logic nclr, input logic nrst);
    exp_t e;
    @(posedge clk);
    if (rst_n) begin
      if (en) begin
        m_yq  = sel(a, c);
        m_par = ($countones(sel(a, c)) % 2) == 1;
      end
      if (clr) m_cnt = 0;
      else if (en && c && m_cnt < MAXC) m_cnt = m_cnt + 1;
    end
    #1;
    a = na; c = nc; en = ne; clr = nclr; rst_n = nrst;
    if (!nrst) begin
      m_yq = '0; m_cnt = 0; m_par = 1'b0;
    end
    e.y   = sel(na, nc);
    e.y_q = m_yq;
    e.cnt = m_cnt;
    e.sat = (m_cnt == MAXC);
    e.y1  = nc ? ~na[0] : na[0];
    e.par = m_par;
    exp_q.push_back(e);
    $display("step a=%02h c=%0b en=%0b clr=%0b rst_n=%0b exp y=%02h y_q=%02h cnt=%0d",
             na, nc, ne, nclr, nrst, e.y, e.y_q, e.cnt);
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("y", 32'(y), 32'(e.y));
      check("y_q", 32'(y_q), 32'(e.y_q));
      check("inv_cnt", 32'(inv_cnt), 32'(e.cnt));
      check("inv_sat", 32'(inv_sat), 32'(e.sat));
      check("y_w1", 32'(y1), 32'(e.y1));
`ifdef MUX_A_NOT_A_PARITY_EN
      check("par_q", 32'(par_q), 32'(e.par));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_yq = '0; m_cnt = 0; m_par = 1'b0;
    // Reset state, then release.
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // 1-bit truth table (also visible on the wide instance).
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    step(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    // Load 5A, then hold with en=0.
    step(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // Saturating count.
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(W'($urandom), 1'b1, 1'b1, 1'b0, 1'b1);
    step(8'h11, 1'b1, 1'b1, 1'b1, 1'b1);
    step(8'h22, 1'b1, 1'b1, 1'b0, 1'b1);
    // Priority: clr beats counting; c=0 does not count.
    step(8'h33, 1'b1, 1'b1, 1'b1, 1'b1);
    step(8'h44, 1'b0, 1'b1, 1'b0, 1'b1);
    step(8'h55, 1'b0, 1'b1, 1'b0, 1'b1);
    // Build inv_cnt=7, y_q=3C, then reset between edges.
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(W'($urandom), 1'b1, 1'b1, 1'b0, 1'b1);
    step(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1);
    step(8'h96, 1'b1, 1'b0, 1'b0, 1'b1);
    step(8'h96, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h69, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(W'($urandom), 1'b1, 1'b1, 1'b0, 1'b1);
    // Parity cases.
    step(8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
    step(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
    step(8'h03, 1'b0, 1'b1, 1'b0, 1'b1);
    step(8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 400; i++) begin
      step(W'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 40) != 0));
    end
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
